inv_sbox_seq: RTL

- Sequencer that shares the single-port, synchronous-read inverse S-box ROM (256x8) across all 16 bytes of an AES state.
- Accepts a 128-bit state over a valid/ready handshake, issues 16 ROM lookups back-to-back, collects the results and presents the substituted state over a valid/ready handshake.
- Sits in the decryption round datapath, in front of the inverse MixColumn stage; it is the only master of the ROM address port.

---
 rtl/inv_sbox_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/inv_sbox_seq.sv
// Shares one synchronous-read inverse S-box ROM across all bytes of an AES state:
// accept a state, issue one lookup per byte, collect the results, hand the state on.
module inv_sbox_seq #(
    parameter int ROM_LAT = 1,
    parameter int NBYTES  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [8*NBYTES-1:0]   in_state,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            rom_adr,
    input  logic [7:0]            rom_dat,
    output logic [8*NBYTES-1:0]   out_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int          IW   = $clog2(NBYTES);
    localparam logic [4:0]  LAST = 5'(NBYTES - 1);
    localparam logic [4:0]  STOP = 5'(NBYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [8*NBYTES-1:0] in_reg;
    logic [8*NBYTES-1:0] out_reg;
    logic [4:0]          issue_cnt;
    logic [4:0]          cap_cnt;
    logic [ROM_LAT-1:0]  pipe_vld;
    logic [IW-1:0]       pipe_idx [ROM_LAT];
    logic                accept;
    logic                cap_en;

    assign accept    = (state == IDLE) && in_valid;
    assign cap_en    = pipe_vld[ROM_LAT-1];
    assign out_state = out_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rom_adr   = 8'h00;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                rom_adr = in_reg[{issue_cnt[IW-1:0], 3'b000} +: 8];
                if (issue_cnt == LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only once the last byte's ROM data has landed in out_reg.
                if (cap_en && (cap_cnt == LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The shift pipe tags each lookup with its byte index so the returning data
    // can be written into the right slot ROM_LAT cycles later.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            in_reg    <= '0;
            out_reg   <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            pipe_vld  <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            if (accept) begin
                in_reg    <= in_state;
                issue_cnt <= '0;
                cap_cnt   <= '0;
            end else begin
                if ((state == ISSUE) && (issue_cnt != STOP)) begin
                    issue_cnt <= issue_cnt + 5'd1;
                end
                if (cap_en) begin
                    cap_cnt <= cap_cnt + 5'd1;
                end
            end
            pipe_vld[0] <= (state == ISSUE);
            pipe_idx[0] <= issue_cnt[IW-1:0];
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            if (cap_en) begin
                out_reg[{pipe_idx[ROM_LAT-1], 3'b000} +: 8] <= rom_dat;
            end
        end
    end

endmodule
